fifo_burst_rd: RTL and testbench

- Read-side drain engine placed directly downstream of the synchronous FIFO (FIFO_DEPTH 16, DATA_WIDTH 32).
- Watches the FIFO fill count and pops data in bursts of a programmable length.
- Forwards the data onto a valid/ready stream, marking the final beat of each burst with m_last.
- Flushes a partial burst after a programmable idle timeout, so residual entries never stall.

---
 rtl/fifo_burst_rd_pkg.sv | 22 ++
 rtl/fifo_burst_rd_if.sv | 53 +++++
 rtl/fifo_burst_skid.sv | 62 ++++++
 rtl/fifo_burst_rd.sv | 131 +++++++++++++
 tb/tb_fifo_burst_rd.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_rd_pkg.sv
// Shared types and helpers for the FIFO burst read engine.
// Holds the FSM encoding, skid depth and burst length clamp.
package fifo_burst_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int SKID_DEPTH = 2;

  function automatic int unsigned clamp_len(
    input int unsigned len,
    input int unsigned depth
  );
    if (len == 0) return 1;
    if (len > depth) return depth;
    return len;
  endfunction

endpackage

// File: rtl/fifo_burst_rd_if.sv
// FIFO-side and stream-side signal bundle for fifo_burst_rd.
// master is the engine view, slave the environment view.
interface fifo_burst_rd_if
  import fifo_burst_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5,
  parameter int TMO_WIDTH  = 16
);
  logic [CNT_WIDTH-1:0]  fifo_cnt;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [CNT_WIDTH-1:0]  burst_len;
  logic [TMO_WIDTH-1:0]  timeout;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  busy;
  logic                  flush_pulse;

  modport master (
    input  fifo_cnt,
    input  fifo_empty,
    input  fifo_rd_data,
    input  burst_len,
    input  timeout,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    output m_last,
    output busy,
    output flush_pulse
  );

  modport slave (
    output fifo_cnt,
    output fifo_empty,
    output fifo_rd_data,
    output burst_len,
    output timeout,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    input  m_last,
    input  busy,
    input  flush_pulse
  );

endinterface

// File: rtl/fifo_burst_skid.sv
// Two-entry valid/ready buffer carrying {last, data}.
// Exposes its occupancy so the reader can meter pops.
module fifo_burst_skid
  import fifo_burst_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occ
);

  localparam int EW = DATA_WIDTH + 1;

  logic [EW-1:0] ent_q [SKID_DEPTH];
  logic [EW-1:0] ent_d [SKID_DEPTH];
  logic [1:0]    cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          pop;
  logic [1:0]    slot;

  always_comb begin
    pop   = vld_q & out_ready;
    ent_d = ent_q;
    cnt_d = cnt_q;
    slot  = cnt_q - {1'b0, pop};
    if (pop) begin
      ent_d[0] = ent_q[1];
      cnt_d    = slot;
    end
    // entry 0 is always the head
    if (in_valid && (slot < 2'(SKID_DEPTH))) begin
      ent_d[slot[0]] = {in_last, in_data};
      cnt_d          = slot + 2'd1;
    end
    vld_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '{default: '0};
      cnt_q <= 2'd0;
      vld_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign out_valid            = vld_q;
  assign {out_last, out_data} = ent_q[0];
  assign occ                  = cnt_q;

endmodule

// File: rtl/fifo_burst_rd.sv
// Burst drain engine behind a synchronous FIFO.
// Pops full bursts, or a partial one after an idle timeout.
module fifo_burst_rd
  import fifo_burst_rd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  =
    ((1 << ADDR_WIDTH) == FIFO_DEPTH) ? ADDR_WIDTH + 1 : ADDR_WIDTH,
  parameter int TMO_WIDTH  = 16
) (
  input logic            clk,
  input logic            rst,
  fifo_burst_rd_if.master bus
);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  pops_q, pops_d;
  logic [TMO_WIDTH-1:0]  tmr_q, tmr_d;
  logic                  pend_q, pend_d;
  logic                  plast_q, plast_d;
  logic [CNT_WIDTH-1:0]  len_l;
  logic                  under;
  logic                  full_trig;
  logic                  tmo_trig;
  logic                  rd_en;
  logic                  busy;
  logic                  fire;
  logic [2:0]            inflight;
  logic                  s_valid;
  logic                  s_last;
  logic [DATA_WIDTH-1:0] s_data;
  logic [1:0]            occ;

  assign len_l = CNT_WIDTH'(clamp_len(32'(bus.burst_len), FIFO_DEPTH));

  assign under = (bus.fifo_cnt != '0) &&
                 (bus.fifo_cnt < len_l);

  assign full_trig = (state_q == IDLE) &&
                     (bus.fifo_cnt >= len_l);

  assign tmo_trig = (state_q == IDLE) && under &&
                    (bus.timeout != '0) &&
                    (tmr_q >= bus.timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pops_q  <= '0;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
      plast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pops_q  <= pops_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      plast_q <= plast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pops_d  = pops_q;
    tmr_d   = '0;
    pend_d  = rd_en;
    plast_d = rd_en && (pops_q == CNT_WIDTH'(1));
    unique case (state_q)
      IDLE: begin
        if (under) begin
          tmr_d = (&tmr_q) ? tmr_q
                           : tmr_q + TMO_WIDTH'(1);
        end
        if (full_trig) begin
          state_d = RUN;
          pops_d  = len_l;
          tmr_d   = '0;
        end else if (tmo_trig) begin
          state_d = RUN;
          pops_d  = bus.fifo_cnt;
          tmr_d   = '0;
        end
      end
      RUN: begin
        pops_d = pops_q - CNT_WIDTH'(rd_en);
        if (pops_d == '0) state_d = DRAIN;
      end
      DRAIN: begin
        if (fire && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fire = s_valid & bus.m_ready;
    // a beat leaving this cycle frees its slot for a new pop
    inflight = {1'b0, occ} - {2'b0, fire} +
               {2'b0, pend_q};
    rd_en = (state_q == RUN) &&
            (pops_q != '0) &&
            !bus.fifo_empty &&
            (inflight < 3'(SKID_DEPTH));
    busy  = (state_q != IDLE);
  end

  fifo_burst_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pend_q),
    .in_last   (plast_q),
    .in_data   (bus.fifo_rd_data),
    .out_valid (s_valid),
    .out_ready (bus.m_ready),
    .out_last  (s_last),
    .out_data  (s_data),
    .occ       (occ)
  );

  assign bus.fifo_rd_en  = rd_en;
  assign bus.m_valid     = s_valid;
  assign bus.m_data      = s_data;
  assign bus.m_last      = s_last;
  assign bus.busy        = busy;
  assign bus.flush_pulse = tmo_trig;

endmodule

// File: tb/tb_fifo_burst_rd.sv
// Bench for fifo_burst_rd: FIFO model plus beat scoreboard.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_fifo_burst_rd;

  localparam int DW = 32;
  localparam int CW = 5;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_burst_rd_if #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .TMO_WIDTH  (TW)
  ) bus ();

  fifo_burst_rd #(
    .FIFO_DEPTH (16),
    .DATA_WIDTH (DW),
    .TMO_WIDTH  (TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic          smp_valid, smp_last, smp_busy;
  logic          smp_fp, smp_rd;
  logic [DW-1:0] smp_data;

  int first_rd, last_rd, rd_cnt;
  int first_v, last_v, v_cnt, lst_cnt;
  int fp_first, fp_cnt;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    first_rd = -1; last_rd = -1; rd_cnt = 0;
    first_v  = -1; last_v  = -1; v_cnt  = 0;
    lst_cnt  = 0;
    fp_first = -1; fp_cnt  = 0;
  endtask

  task automatic sync_fifo();
    bus.fifo_cnt   = CW'(fifo_q.size());
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push_words(input logic [DW-1:0] base,
                            input int n,
                            input int per);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      exp_q.push_back('{l: ((i + 1) % per == 0) ||
                           (i == n - 1),
                        d: base + DW'(i)});
    end
    sync_fifo();
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    smp_valid = bus.m_valid;
    smp_data  = bus.m_data;
    smp_last  = bus.m_last;
    smp_busy  = bus.busy;
    smp_fp    = bus.flush_pulse;
    smp_rd    = bus.fifo_rd_en;
    if (smp_rd) begin
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      rd_cnt++;
      chk("rd_nonempty", (fifo_q.size() != 0), 1);
    end
    if (smp_fp) begin
      if (fp_first < 0) fp_first = cyc;
      fp_cnt++;
    end
    if (smp_valid && bus.m_ready) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      v_cnt++;
      if (smp_last) lst_cnt++;
      chk("sb_have_exp", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", smp_data, e.d);
        chk("sb_last", smp_last, e.l);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (smp_rd && fifo_q.size() != 0)
      bus.fifo_rd_data = fifo_q.pop_front();
    sync_fifo();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || smp_busy) &&
           n < budget) begin
      tick();
      n++;
    end
    chk(tag, (exp_q.size() == 0 && !smp_busy), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r;
    bus.fifo_cnt     = '0;
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;
    bus.burst_len    = CW'(4);
    bus.timeout      = '0;
    bus.m_ready      = 1'b1;
    smp_busy         = 1'b0;
    clr_stats();

    tick();
    tick();
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_last", bus.m_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_flush", bus.flush_pulse, 0);
    rst = 1'b0;
    tick();
    tick();

    // full burst of four
    clr_stats();
    push_words(32'hA0, 4, 4);
    c0 = cyc;
    drain("t1_done", 40);
    chk("t1_rd_first", first_rd, c0 + 1);
    chk("t1_rd_cnt", rd_cnt, 4);
    chk("t1_rd_run", last_rd - first_rd, 3);
    chk("t1_v_first", first_v, c0 + 3);
    chk("t1_v_run", last_v - first_v, 3);
    chk("t1_v_cnt", v_cnt, 4);
    chk("t1_busy_end", smp_busy, 0);

    // timeout flush of a partial burst
    bus.burst_len = CW'(8);
    bus.timeout   = TW'(10);
    clr_stats();
    push_words(32'hB0, 3, 3);
    c0 = cyc;
    drain("t2_done", 60);
    chk("t2_fp_cyc", fp_first, c0 + 10);
    chk("t2_fp_cnt", fp_cnt, 1);
    chk("t2_v_cnt", v_cnt, 3);
    chk("t2_lst_cnt", lst_cnt, 1);

    // timeout disabled: residue stays put
    bus.timeout = '0;
    clr_stats();
    push_words(32'hC0, 3, 3);
    repeat (40) tick();
    chk("t2z_v_cnt", v_cnt, 0);
    chk("t2z_fp_cnt", fp_cnt, 0);
    chk("t2z_rd_cnt", rd_cnt, 0);
    bus.burst_len = CW'(3);
    drain("t2z_done", 40);
    chk("t2z_v_after", v_cnt, 3);

    // backpressure
    bus.burst_len = CW'(4);
    bus.m_ready   = 1'b0;
    clr_stats();
    push_words(32'hD0, 4, 4);
    for (int n = 0; n < 20 && !smp_valid; n++)
      tick();
    chk("t3_valid", smp_valid, 1);
    chk("t3_head", smp_data, exp_q[0].d);
    c0 = 0;
    repeat (6) begin
      tick();
      chk("t3_hold_data", smp_data, exp_q[0].d);
      chk("t3_hold_last", smp_last, exp_q[0].l);
    end
    chk("t3_pops_max2", (rd_cnt <= 2), 1);
    bus.m_ready = 1'b1;
    drain("t3_done", 40);
    chk("t3_v_cnt", v_cnt, 4);

    // back-to-back bursts from a full FIFO
    clr_stats();
    push_words(32'h100, 16, 4);
    drain("t4_done", 200);
    chk("t4_v_cnt", v_cnt, 16);
    chk("t4_rd_cnt", rd_cnt, 16);
    chk("t4_lst_cnt", lst_cnt, 4);

    // oversized burst_len clamps to depth
    bus.burst_len = CW'(20);
    clr_stats();
    push_words(32'h200, 16, 16);
    drain("t4c_done", 200);
    chk("t4c_v_cnt", v_cnt, 16);
    chk("t4c_lst_cnt", lst_cnt, 1);

    // reset in the middle of a burst
    bus.burst_len = CW'(4);
    clr_stats();
    push_words(32'hE0, 6, 4);
    for (int n = 0; n < 30 && v_cnt < 2; n++)
      tick();
    chk("t5_two_beats", v_cnt, 2);
    rst = 1'b1;
    #1;
    chk("t5_rd_en", bus.fifo_rd_en, 0);
    chk("t5_valid", bus.m_valid, 0);
    chk("t5_data", bus.m_data, 0);
    chk("t5_last", bus.m_last, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_flush", bus.flush_pulse, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("t5_idle_busy", bus.busy, 0);
    chk("t5_idle_rd", bus.fifo_rd_en, 0);
    r = fifo_q.size();
    chk("t5_left", r, 2);
    for (int i = 0; i < r; i++)
      exp_q.push_back('{l: (i == r - 1), d: fifo_q[i]});
    bus.burst_len = CW'(r);
    clr_stats();
    drain("t5_done", 40);
    chk("t5_v_cnt", v_cnt, r);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
